// File: rtl/avst_combiner_pkg.sv
// Shared types and helpers for the Avalon-ST stream combiner.
//   mode_e  : combine mode (round-robin merge, sum join, max join, reserved).
//   rr_next : round-robin grant search over a non-empty mask.
package avst_combiner_pkg;

  localparam int MAX_CH = 8;

  typedef enum logic [1:0] {
    MODE_RR   = 2'd0,
    MODE_SUM  = 2'd1,
    MODE_MAX  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  // First set bit of nonempty_mask searching upward from ptr+1 with wrap at
  // n_ch. The loop walks from the farthest candidate to the nearest so the
  // nearest non-empty channel is the one left in grant. Returns ptr when the
  // mask is empty (callers only use the grant when something is non-empty).
  function automatic logic [2:0] rr_next(input logic [2:0] ptr,
                                         input logic [MAX_CH-1:0] nonempty_mask,
                                         input int n_ch);
    logic [2:0] grant;
    int         idx;
    grant = ptr;
    for (int k = MAX_CH; k >= 1; k--) begin
      if (k <= n_ch) begin
        idx = (int'(ptr) + k) % n_ch;
        if (nonempty_mask[idx[2:0]]) grant = idx[2:0];
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/avst_stream_combiner_if.sv
// Avalon-ST bundle for the stream combiner: N_CH input channels in, one
// stream out, plus the runtime mode select.
//   slave  : the combiner's view (consumes inputs, drives the output stream).
//   master : the environment's view (drives inputs, consumes the output).
interface avst_stream_combiner_if #(
  parameter int DATA_W = 32,
  parameter int N_CH   = 2
);
  localparam int CH_W = $clog2(N_CH);

  logic [1:0]             mode;
  logic [N_CH*DATA_W-1:0] in_data;
  logic [N_CH-1:0]        in_valid;
  logic [N_CH-1:0]        in_ready;
  logic [DATA_W-1:0]      out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [CH_W-1:0]        out_ch;
  logic                   out_ovf;

  modport slave (
    input  mode, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ch, out_ovf
  );

  modport master (
    output mode, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ch, out_ovf
  );
endinterface

// File: rtl/avst_fifo.sv
// Synchronous FIFO with asynchronous active-low reset.
//   push/wdata : write one entry (ignored when full).
//   pop        : drop the head entry (ignored when empty).
//   rdata      : current head, read combinationally from storage.
//   full/empty : derived from the registered occupancy count.
module avst_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) wide so they wrap without compare logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; stale contents are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/avst_stream_combiner.sv
// N-channel Avalon-ST combiner. Each input channel is buffered in its own
// FIFO; a combine stage selects or merges the FIFO heads according to mode
// and a registered output stage presents the result downstream.
//   clk, rst_n : clock and asynchronous active-low reset.
//   bus.mode   : 0 RR merge, 1 sum join, 2 max join, 3 behaves as 0.
//   bus.in_*   : per-channel data/valid/ready, channel i at [i*DATA_W +: DATA_W].
//   bus.out_*  : output beat, valid/ready, source channel (RR) and sum overflow.
module avst_stream_combiner
  import avst_combiner_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int N_CH       = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  avst_stream_combiner_if.slave bus
);
  localparam int CH_W  = $clog2(N_CH);
  localparam int SUM_W = DATA_W + CH_W;

  // Full-precision sum of all heads; the bits above DATA_W flag overflow.
  function automatic logic [SUM_W-1:0] sum_heads(input logic [N_CH*DATA_W-1:0] heads);
    logic [SUM_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < N_CH; i++) acc = acc + SUM_W'(heads[i*DATA_W +: DATA_W]);
    return acc;
  endfunction

  function automatic logic [DATA_W-1:0] max_heads(input logic [N_CH*DATA_W-1:0] heads);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (heads[i*DATA_W +: DATA_W] > m) m = heads[i*DATA_W +: DATA_W];
    end
    return m;
  endfunction

  logic [N_CH-1:0]        full;
  logic [N_CH-1:0]        empty;
  logic [N_CH-1:0]        in_ready_w;
  logic [N_CH-1:0]        push;
  logic                   ready_en;

  logic [N_CH*DATA_W-1:0] heads_p0;
  logic [N_CH-1:0]        nonempty_p0;
  logic [N_CH-1:0]        pop_p0;
  mode_e                  mode_p0;
  logic [CH_W-1:0]        grant_p0;
  logic [SUM_W-1:0]       sum_p0;
  logic                   fire_p0;
  logic                   load_p0;
  logic [DATA_W-1:0]      data_p0;
  logic [CH_W-1:0]        ch_p0;
  logic                   ovf_p0;

  logic                   vld_p1;
  logic [DATA_W-1:0]      data_p1;
  logic [CH_W-1:0]        ch_p1;
  logic                   ovf_p1;
  logic [CH_W-1:0]        rr_ptr;

  // ready_en holds in_ready low through reset and opens it on the first edge
  // after release; ready never looks at out_ready.
  assign in_ready_w   = {N_CH{ready_en}} & ~full;
  assign push         = bus.in_valid & in_ready_w;
  assign bus.in_ready = in_ready_w;

  // ---- stage p0: per-channel input buffering ----
  for (genvar i = 0; i < N_CH; i++) begin : g_fifo
    avst_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .pop   (pop_p0[i]),
      .wdata (bus.in_data[i*DATA_W +: DATA_W]),
      .rdata (heads_p0[i*DATA_W +: DATA_W]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  assign nonempty_p0 = ~empty;
  assign grant_p0    = CH_W'(rr_next(3'(rr_ptr), MAX_CH'(nonempty_p0), N_CH));

  // ---- stage p0: combine and load decision ----
  always_comb begin
    mode_p0 = mode_e'(bus.mode);
    if (mode_p0 == MODE_RSVD) mode_p0 = MODE_RR;

    sum_p0  = sum_heads(heads_p0);
    fire_p0 = 1'b0;
    data_p0 = '0;
    ch_p0   = '0;
    ovf_p0  = 1'b0;
    case (mode_p0)
      MODE_SUM: begin
        fire_p0 = &nonempty_p0;
        data_p0 = sum_p0[DATA_W-1:0];
        ovf_p0  = |sum_p0[SUM_W-1:DATA_W];
      end
      MODE_MAX: begin
        fire_p0 = &nonempty_p0;
        data_p0 = max_heads(heads_p0);
      end
      default: begin
        fire_p0 = |nonempty_p0;
        data_p0 = heads_p0[int'(grant_p0)*DATA_W +: DATA_W];
        ch_p0   = grant_p0;
      end
    endcase

    load_p0 = (!vld_p1 || bus.out_ready) && fire_p0;
    pop_p0  = '0;
    if (load_p0) pop_p0 = (mode_p0 == MODE_RR) ? (N_CH'(1) << grant_p0) : {N_CH{1'b1}};
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      rr_ptr   <= CH_W'(N_CH - 1);
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      ch_p1    <= '0;
      ovf_p1   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (load_p0) begin
        vld_p1  <= 1'b1;
        data_p1 <= data_p0;
        ch_p1   <= ch_p0;
        ovf_p1  <= ovf_p0;
        // Only RR loads advance fairness; join loads consume every channel.
        if (mode_p0 == MODE_RR) rr_ptr <= grant_p0;
      end else if (bus.out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_ch    = ch_p1;
  assign bus.out_ovf   = ovf_p1;

endmodule
